// File: rtl/icache_pkg.sv
// Shared i-cache types: refill FSM states, line geometry and the line payload type.
package icache_pkg;

    localparam int unsigned IC_DATA_WIDTH = 32;
    localparam int unsigned IC_ADDR_WIDTH = 32;
    localparam int unsigned IC_LINE_SIZE  = 4;
    localparam int unsigned OFF_W         = $clog2(IC_LINE_SIZE);
    localparam int unsigned LINE_BYTES    = IC_LINE_SIZE * (IC_DATA_WIDTH / 8);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        FILL
    } refill_state_e;

    typedef logic [IC_DATA_WIDTH*IC_LINE_SIZE-1:0] line_t;

endpackage

// File: rtl/icache_refill_line_buf.sv
// Line assembly buffer: one register per word slot, written by slot index, read flat.
module refill_line_buf #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LINE_SIZE  = 4
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             i_we,
    input  logic [$clog2(LINE_SIZE)-1:0]     i_slot,
    input  logic [DATA_WIDTH-1:0]            i_wdata,
    output logic [DATA_WIDTH*LINE_SIZE-1:0]  o_line
);

    logic [DATA_WIDTH-1:0] r_word [LINE_SIZE];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(LINE_SIZE); i++) begin
                r_word[i] <= '0;
            end
        end else if (i_we) begin
            r_word[i_slot] <= i_wdata;
        end
    end

    for (genvar g = 0; g < int'(LINE_SIZE); g++) begin : g_flat
        assign o_line[g*DATA_WIDTH +: DATA_WIDTH] = r_word[g];
    end

endmodule

// File: rtl/icache_refill.sv
// Critical-word-first line refill engine between the i-cache miss path and
// a single-word instruction memory; one miss in flight at a time.
module icache_refill #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_SIZE  = 4
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             miss_valid,
    input  logic [ADDR_WIDTH-1:0]            miss_addr,
    output logic                             miss_ready,
    output logic                             mem_req,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    input  logic                             mem_ready,
    input  logic                             mem_rvalid,
    input  logic [DATA_WIDTH-1:0]            mem_rdata,
    output logic                             crit_valid,
    output logic [DATA_WIDTH-1:0]            crit_data,
    output logic                             fill_valid,
    output logic [ADDR_WIDTH-1:0]            fill_addr,
    output logic [DATA_WIDTH*LINE_SIZE-1:0]  fill_data,
    output logic                             busy
);

    import icache_pkg::*;

    localparam int unsigned OFF_W = $clog2(LINE_SIZE);
    localparam int unsigned CNT_W = OFF_W + 1;
    localparam int unsigned LSB_W = OFF_W + 2;

    refill_state_e         r_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [OFF_W-1:0]      r_crit;
    logic [CNT_W-1:0]      r_issue_cnt;
    logic [CNT_W-1:0]      r_resp_cnt;

    logic                  w_req_st;
    logic                  w_rsp_en;
    logic                  w_accept;
    logic                  w_wr_en;
    logic                  w_last_issue;
    logic                  w_last_resp;
    logic [OFF_W-1:0]      w_issue_slot;
    logic [OFF_W-1:0]      w_resp_slot;
    logic                  w_unused;

    assign w_req_st     = (r_state == REQ);
    assign w_rsp_en     = w_req_st || (r_state == WAIT);
    assign w_accept     = w_req_st && mem_ready;
    assign w_wr_en      = w_rsp_en && mem_rvalid;
    assign w_last_issue = (r_issue_cnt == CNT_W'(LINE_SIZE - 1));
    assign w_last_resp  = w_wr_en && (r_resp_cnt == CNT_W'(LINE_SIZE - 1));

    // Offsets are OFF_W bits wide so the critical-word-first order wraps naturally.
    assign w_issue_slot = r_crit + r_issue_cnt[OFF_W-1:0];
    assign w_resp_slot  = r_crit + r_resp_cnt[OFF_W-1:0];
    assign w_unused     = ^miss_addr[1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_base      <= '0;
            r_crit      <= '0;
            r_issue_cnt <= '0;
            r_resp_cnt  <= '0;
        end else begin
            if (w_wr_en) begin
                r_resp_cnt <= r_resp_cnt + CNT_W'(1);
            end
            case (r_state)
                IDLE: begin
                    if (miss_valid) begin
                        r_base  <= {miss_addr[ADDR_WIDTH-1:LSB_W], LSB_W'(0)};
                        r_crit  <= miss_addr[LSB_W-1:2];
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (w_accept) begin
                        r_issue_cnt <= r_issue_cnt + CNT_W'(1);
                        if (w_last_issue) begin
                            r_state <= w_last_resp ? FILL : WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (w_last_resp) begin
                        r_state <= FILL;
                    end
                end
                FILL: begin
                    r_issue_cnt <= '0;
                    r_resp_cnt  <= '0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    refill_line_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .LINE_SIZE  (LINE_SIZE)
    ) u_line_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .i_we    (w_wr_en),
        .i_slot  (w_resp_slot),
        .i_wdata (mem_rdata),
        .o_line  (fill_data)
    );

    assign miss_ready = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign mem_req    = w_req_st;
    assign mem_addr   = r_base | (ADDR_WIDTH'(w_issue_slot) << 2);
    assign crit_valid = w_wr_en && (r_resp_cnt == '0);
    assign crit_data  = mem_rdata;
    assign fill_valid = (r_state == FILL);
    assign fill_addr  = r_base;

endmodule

// File: tb/tb_icache_refill.sv
// Scoreboard bench for icache_refill: memory returns its own address as data.
module tb_icache_refill;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          miss_valid = 1'b0;
    logic [31:0]   miss_addr = '0;
    logic          miss_ready;
    logic          mem_req;
    logic [31:0]   mem_addr;
    logic          mem_ready;
    logic          mem_rvalid;
    logic [31:0]   mem_rdata;
    logic          crit_valid;
    logic [31:0]   crit_data;
    logic          fill_valid;
    logic [31:0]   fill_addr;
    logic [127:0]  fill_data;
    logic          busy;

    logic          lat0 = 1'b0;
    logic          rdy = 1'b1;
    logic          stray_rv = 1'b0;
    logic [31:0]   stray_data = '0;
    logic          r_v = 1'b0;
    logic [31:0]   r_d = '0;

    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            acc_cyc = 0;
    int            fill_cnt = 0;
    int            last_fill_cyc = 0;
    int            last_fill_delta = 0;
    int            last_crit_delta = 0;

    logic [31:0]   exp_addr_q [$];
    logic [31:0]   exp_crit_q [$];
    logic [31:0]   exp_base_q [$];
    logic [127:0]  exp_line_q [$];

    icache_refill dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .miss_valid (miss_valid),
        .miss_addr  (miss_addr),
        .miss_ready (miss_ready),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .crit_valid (crit_valid),
        .crit_data  (crit_data),
        .fill_valid (fill_valid),
        .fill_addr  (fill_addr),
        .fill_data  (fill_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Memory model: zero-latency (combinational) or one-cycle registered response.
    assign mem_ready  = rdy;
    assign mem_rvalid = stray_rv | (lat0 ? (mem_req && mem_ready) : r_v);
    assign mem_rdata  = stray_rv ? stray_data : (lat0 ? mem_addr : r_d);

    always @(posedge clk) begin
        r_v <= !lat0 && mem_req && mem_ready;
        r_d <= mem_addr;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_expected(input logic [31:0] a);
        logic [31:0]  base;
        logic [1:0]   c;
        logic [127:0] line;
        base = a & ~32'hF;
        c    = a[3:2];
        for (int i = 0; i < 4; i++) begin
            exp_addr_q.push_back(base + 32'(((int'(c) + i) % 4) * 4));
        end
        exp_crit_q.push_back(base + 32'(int'(c) * 4));
        for (int k = 0; k < 4; k++) begin
            line[k*32 +: 32] = base + 32'(k * 4);
        end
        exp_base_q.push_back(base);
        exp_line_q.push_back(line);
    endtask

    // Monitor: scoreboard pops plus protocol properties, sampled mid-cycle.
    initial begin
        logic        prev_fill;
        logic        prev_stall;
        logic [31:0] prev_addr;
        prev_fill  = 1'b0;
        prev_stall = 1'b0;
        prev_addr  = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_fill  = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (miss_valid && miss_ready) begin
                    push_expected(miss_addr);
                    acc_cyc = cyc;
                end
                if (mem_req && mem_ready) begin
                    if (exp_addr_q.size() == 0) check("addr_unexpected", 1, 0);
                    else check("mem_addr", mem_addr, exp_addr_q.pop_front());
                end
                if (crit_valid) begin
                    last_crit_delta = cyc - acc_cyc;
                    if (exp_crit_q.size() == 0) check("crit_unexpected", 1, 0);
                    else check("crit_data", crit_data, exp_crit_q.pop_front());
                end
                if (fill_valid) begin
                    fill_cnt++;
                    last_fill_cyc   = cyc;
                    last_fill_delta = cyc - acc_cyc;
                    if (exp_base_q.size() == 0) check("fill_unexpected", 1, 0);
                    else begin
                        check("fill_addr", fill_addr, exp_base_q.pop_front());
                        check("fill_data", fill_data, exp_line_q.pop_front());
                    end
                end
                if (prev_fill) check("fill_one_cycle", fill_valid, 0);
                if (prev_stall) begin
                    check("req_held", mem_req, 1);
                    check("addr_held", mem_addr, prev_addr);
                end
                if (busy) check("resp_le_issue", dut.r_resp_cnt <= dut.r_issue_cnt, 1);
                prev_fill  = fill_valid;
                prev_stall = mem_req && !mem_ready;
                prev_addr  = mem_addr;
            end
        end
    end

    task automatic start_miss(input logic [31:0] a);
        @(posedge clk);
        #1;
        miss_valid = 1'b1;
        miss_addr  = a;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (miss_ready) break;
        end
        if (!miss_ready) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        miss_valid = 1'b0;
    endtask

    task automatic wait_fill(input int n0);
        for (int n = 0; n < 80; n++) begin
            if (fill_cnt != n0) break;
            @(posedge clk);
            #1;
        end
        if (fill_cnt == n0) check("fill_timeout", 0, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_miss_ready"}, miss_ready, 1);
        check({tag, "_mem_req"}, mem_req, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_fill_valid"}, fill_valid, 0);
        check({tag, "_crit_valid"}, crit_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_fill_data"}, fill_data, 0);
    endtask

    initial begin
        int n0;

        #2 reset_n = 1'b0;
        #3;
        check_idle_outputs("rst");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Basic refill, one-cycle memory.
        n0 = fill_cnt;
        start_miss(32'h0000_0108);
        wait_fill(n0);
        check("t1_crit_lat", last_crit_delta, 2);
        check("t1_fill_lat", last_fill_delta, 6);

        // Memory stalls three cycles on the second request.
        n0 = fill_cnt;
        start_miss(32'h0000_2204);
        @(posedge clk);
        #1 rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rdy = 1'b1;
        wait_fill(n0);
        check("t2_fill_lat", last_fill_delta, 9);

        // Zero-latency memory.
        lat0 = 1'b1;
        n0 = fill_cnt;
        start_miss(32'h0000_3008);
        wait_fill(n0);
        check("t3_crit_lat", last_crit_delta, 1);
        check("t3_fill_lat", last_fill_delta, 5);

        // Every critical offset, both latencies.
        for (int c = 0; c < 4; c++) begin
            lat0 = c[0];
            n0 = fill_cnt;
            start_miss(32'h0000_4000 + 32'(c * 32'h44));
            wait_fill(n0);
            check("wrap_fill_lat", last_fill_delta, lat0 ? 5 : 6);
        end
        lat0 = 1'b0;

        // Miss held through a refill with a new address.
        n0 = fill_cnt;
        @(posedge clk);
        #1;
        miss_valid = 1'b1;
        miss_addr  = 32'h0000_5104;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (miss_ready) break;
        end
        @(posedge clk);
        #1 miss_addr = 32'h0000_6208;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (miss_ready) break;
        end
        check("t4_second_ready", miss_ready, 1);
        check("t4_fills_before", fill_cnt, n0 + 1);
        check("t4_accept_cycle", cyc, last_fill_cyc + 1);
        @(posedge clk);
        #1 miss_valid = 1'b0;
        wait_fill(n0 + 1);
        check("t4_fill_lat", last_fill_delta, 6);

        // Reset after two responses, then stray data in IDLE.
        n0 = fill_cnt;
        start_miss(32'h0000_7000);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check_idle_outputs("t5");
        exp_addr_q.delete();
        exp_crit_q.delete();
        exp_base_q.delete();
        exp_line_q.delete();
        @(posedge clk);
        #1 reset_n = 1'b1;
        stray_rv   = 1'b1;
        stray_data = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 stray_rv = 1'b0;
        check("t5_stray_busy", busy, 0);
        check("t5_stray_ready", miss_ready, 1);
        start_miss(32'h0000_700C);
        wait_fill(n0);
        check("t5_fill_count", fill_cnt, n0 + 1);
        check("t5_fill_lat", last_fill_delta, 6);

        repeat (3) @(posedge clk);
        check("sb_empty", exp_addr_q.size() + exp_crit_q.size() + exp_base_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
